stream_demux4: RTL and testbench

STREAM_DEMUX4 -- requirements
Module: stream_demux4

---
 rtl/common_pkg.sv | 4 +
 rtl/common_mux.sv | 13 +
 rtl/stream_demux4_slot.sv | 67 ++++++
 rtl/stream_demux4.sv | 52 +++++
 tb/tb_stream_demux4.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared constants for the streaming datapath blocks.
package common_pkg;
    localparam int DEFAULT_D_W = 8;
endpackage

// File: rtl/common_mux.sv
// Generic N:1 mux of W-bit words selected by a binary index.
// Latency: combinational. Backpressure: none, pure select.
module common_mux #(
    parameter int N = 4,
    parameter int W = 1,
    localparam int L = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0][W-1:0] d,
    input  logic [L-1:0]        sel,
    output logic [W-1:0]        q
);
    assign q = d[sel];
endmodule

// File: rtl/stream_demux4_slot.sv
// One output slot of stream_demux4: register stage (default) or 2-entry skid (STREAM_DEMUX4_SKID_EN).
// Latency 1 cycle; in_ready is combinational from out_ready by default, registered-only with skid.
module stream_demux4_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
`ifdef STREAM_DEMUX4_SKID_EN
    logic [W-1:0] tail;
    logic         full;
    logic         push;
    logic         pop;

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = out_valid && out_ready;

    // full means head and tail both hold words; tail is always the younger one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            tail      <= '0;
            full      <= 1'b0;
        end else if (full) begin
            if (pop) begin
                out_data <= tail;
                full     <= 1'b0;
            end
        end else if (push && (!out_valid || pop)) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (push) begin
            tail <= in_data;
            full <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`else
    logic push;
    logic pop;

    assign in_ready = !out_valid || out_ready;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (push) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: rtl/stream_demux4.sv
// 1-to-4 valid/ready stream demux routing each word to the slot named by i_sel; macro STREAM_DEMUX4_SKID_EN deepens slots.
// Latency 1 cycle; a stalled output only holds back words aimed at that same output.
module stream_demux4
    import common_pkg::*;
#(
    parameter  int W = DEFAULT_D_W,
    localparam int N = 4,
    localparam int L = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [L-1:0]        i_sel,
    input  logic [W-1:0]        i_data,
    output logic [N-1:0]        o_valid,
    input  logic [N-1:0]        o_ready,
    output logic [N-1:0][W-1:0] o_data
);
    logic [N-1:0]      wr_en;
    logic [N-1:0][0:0] slot_rdy;
    logic [0:0]        sel_rdy;

    always_comb begin
        wr_en = '0;
        if (i_valid) begin
            wr_en[i_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        stream_demux4_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (wr_en[k]),
            .in_ready  (slot_rdy[k][0]),
            .in_data   (i_data),
            .out_valid (o_valid[k]),
            .out_ready (o_ready[k]),
            .out_data  (o_data[k])
        );
    end

    common_mux #(.N(N), .W(1)) u_rdy_mux (
        .d   (slot_rdy),
        .sel (i_sel),
        .q   (sel_rdy)
    );

    // Slots look ready while held in reset; keep the handshake closed until release.
    assign i_ready = rst_n && sel_rdy[0];
endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4: directed scenarios then random traffic against a per-port queue model.
module tb_stream_demux4;
    import common_pkg::*;

    localparam int W = DEFAULT_D_W;
`ifdef STREAM_DEMUX4_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                i_valid;
    logic                i_ready;
    logic [1:0]          i_sel;
    logic [W-1:0]        i_data;
    logic [3:0]          o_valid;
    logic [3:0]          o_ready;
    logic [3:0][W-1:0]   o_data;

    stream_demux4 #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_sel   (i_sel),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data)
    );

    typedef logic [W-1:0] wq_t[$];
    wq_t q[4];

    int errors  = 0;
    int checks  = 0;
    int acc_cnt = 0;
    bit known     = 1'b0;
    bit after_rst = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A port accepts when its pending count is below capacity, or (single register) when it drains this cycle.
    function automatic bit exp_rdy(input logic [1:0] s, input logic [3:0] r);
        if (CAP == 2) return q[s].size() < 2;
        return (q[s].size() == 0) || r[s];
    endfunction

    task automatic cycle(input bit rst, input bit v, input logic [1:0] s,
                         input logic [W-1:0] d, input logic [3:0] r, input string tag);
        bit er;
        bit acc;
        rst_n   = !rst;
        i_valid = v;
        i_sel   = s;
        i_data  = d;
        o_ready = r;
        #1;
        er = !rst && exp_rdy(s, r);
        if (known || rst) chk({tag, "_rdy"}, {31'd0, i_ready}, {31'd0, er});
        if (known) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s_v%0d", tag, k), {31'd0, o_valid[k]}, (q[k].size() > 0) ? 32'd1 : 32'd0);
                if (q[k].size() > 0)
                    chk($sformatf("%s_d%0d", tag, k), 32'(o_data[k]), 32'(q[k][0]));
                else if (after_rst)
                    chk($sformatf("%s_z%0d", tag, k), 32'(o_data[k]), 32'd0);
            end
        end
        acc = v && er;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 4; k++) q[k].delete();
            known     = 1'b1;
            after_rst = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (q[k].size() > 0 && r[k]) void'(q[k].pop_front());
            if (acc) begin
                q[s].push_back(d);
                acc_cnt++;
            end
            after_rst = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int start;
        int n;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_sel   = 2'd0;
        i_data  = '0;
        o_ready = 4'hF;

        // Reset held three cycles with a word offered; nothing may leak out after release.
        for (int i = 0; i < 3; i++) cycle(1, 1, 2'(i), 8'hEE, 4'hF, "rst");
        chk("rst_ov", {28'd0, o_valid}, 32'd0);
        cycle(0, 0, 2'd0, 8'h00, 4'hF, "rel");
        cycle(0, 0, 2'd0, 8'h00, 4'hF, "rel");
        chk("rel_ov", {28'd0, o_valid}, 32'd0);

        // Back-to-back streaming to every port.
        cycle(0, 1, 2'd0, 8'h11, 4'hF, "str");
        cycle(0, 1, 2'd1, 8'h22, 4'hF, "str");
        cycle(0, 1, 2'd2, 8'h33, 4'hF, "str");
        cycle(0, 1, 2'd3, 8'h44, 4'hF, "str");
        chk("str_d3", 32'(o_data[3]), 32'h44);
        cycle(0, 0, 2'd0, 8'h00, 4'hF, "str");

        // Port 2 stalled; port 1 must still get through.
        cycle(0, 1, 2'd2, 8'hA0, 4'b1011, "bp");
        cycle(0, 1, 2'd2, 8'hA1, 4'b1011, "bp");
        cycle(0, 1, 2'd2, 8'hA1, 4'b1011, "bp");
        cycle(0, 1, 2'd1, 8'hB0, 4'b1011, "bp");
        chk("bp_b0", 32'(o_data[1]), 32'hB0);
        cycle(0, 0, 2'd0, 8'h00, 4'b1011, "bp");
        chk("bp_hold", 32'(o_data[2]), 32'hA0);
        chk("bp_v2", {31'd0, o_valid[2]}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 2'd0, 8'h00, 4'hF, "bpd");

        // Drain and refill port 0 in the same cycle.
        cycle(0, 1, 2'd0, 8'h05, 4'b1110, "df");
        chk("df_5", 32'(o_data[0]), 32'h05);
        cycle(0, 1, 2'd0, 8'h06, 4'hF, "df");
        chk("df_6", 32'(o_data[0]), 32'h06);
        chk("df_v0", {31'd0, o_valid[0]}, 32'd1);
        cycle(0, 0, 2'd0, 8'h00, 4'hF, "df");

        // Reset while port 3 holds a word.
        cycle(0, 1, 2'd3, 8'h77, 4'b0111, "mr");
        cycle(0, 0, 2'd0, 8'h00, 4'b0111, "mr");
        chk("mr_hold", 32'(o_data[3]), 32'h77);
        cycle(1, 0, 2'd0, 8'h00, 4'b0111, "mr");
        chk("mr_v3", {31'd0, o_valid[3]}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 2'd0, 8'h00, 4'hF, "mrp");

        // Random traffic.
        start = acc_cnt;
        n = 0;
        while ((acc_cnt - start) < 10000 && n < 60000) begin
            logic [3:0] r;
            for (int k = 0; k < 4; k++) r[k] = ($urandom_range(3) != 0);
            cycle(0, $urandom_range(4) != 0, 2'($urandom_range(3)), W'($urandom), r, "rnd");
            n++;
        end
        chk("rnd_cnt", ((acc_cnt - start) >= 10000) ? 32'd1 : 32'd0, 32'd1);

        for (int i = 0; i < 4; i++) cycle(0, 0, 2'd0, 8'h00, 4'hF, "end");
        chk("end_empty", {28'd0, o_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
